// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, raw scan-result encoding, debounce states and the
// PmodKYPD row/column to key-code map shared by the keypad scanner blocks.
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // raw result: bit4=0 -> single key in [3:0]; bit4=1 -> special sentinel
  localparam logic [4:0] RAW_NONE  = 5'h10;
  localparam logic [4:0] RAW_MULTI = 5'h11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_0;
      4'b11_01: code = KEY_F;
      4'b11_10: code = KEY_E;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: turns one raw result per full scan into a single
// qualified key code per physical press.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
//
// state        | meaning
// IDLE         | no key accepted, waiting for a single key
// PRESS_WAIT   | same single key seen cnt consecutive scans
// HELD         | key reported, waiting for release
// RELEASE_WAIT | no key seen cnt consecutive scans
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_stb,
  input  logic [4:0] raw,
  output logic [3:0] decode,
  output logic       key_valid
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  db_state_t  state;
  logic [3:0] cand;
  logic [3:0] cnt;
  logic       is_single;
  logic       is_cand;
  logic       is_none;

  assign is_single = ~raw[4];
  assign is_cand   = (raw == {1'b0, cand});
  assign is_none   = (raw == RAW_NONE);

`ifdef KEYPAD_REPEAT_EN
  // down-counter to the next repeat; first reload is one short because the
  // accepting scan already counts as the first held scan
  localparam logic [15:0] RPT_FIRST = (REPEAT_DELAY > 1) ? 16'(REPEAT_DELAY - 1) : 16'd1;
  localparam logic [15:0] RPT_NEXT  = (REPEAT_PERIOD > 0) ? 16'(REPEAT_PERIOD) : 16'd1;
  logic [15:0] rpt_cnt;
`else
  // repeat timing parameters have no effect in this build
  logic unused_rpt;
  assign unused_rpt = (REPEAT_DELAY + REPEAT_PERIOD) != 0;
`endif

  // debounce FSM, advanced only on the per-scan strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= 4'h0;
      cnt       <= 4'h0;
      decode    <= 4'h0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= 16'd0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (scan_stb) begin
        case (state)
          IDLE: begin
            if (is_single) begin
              cand <= raw[3:0];
              if (DB_TARGET == 4'd1) begin
                decode    <= raw[3:0];
                key_valid <= 1'b1;
                cnt       <= DB_TARGET;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rpt_cnt   <= RPT_FIRST;
`endif
              end else begin
                cnt   <= 4'd1;
                state <= PRESS_WAIT;
              end
            end
          end
          PRESS_WAIT: begin
            if (is_cand) begin
              if (cnt + 4'd1 == DB_TARGET) begin
                decode    <= cand;
                key_valid <= 1'b1;
                cnt       <= DB_TARGET;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rpt_cnt   <= RPT_FIRST;
`endif
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (is_none) begin
              cnt   <= 4'd1;
              state <= (DB_TARGET == 4'd1) ? IDLE : RELEASE_WAIT;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (is_cand) begin
              if (rpt_cnt == 16'd1) begin
                key_valid <= 1'b1;
                rpt_cnt   <= RPT_NEXT;
              end else begin
                rpt_cnt <= rpt_cnt - 16'd1;
              end
            end
`endif
          end
          RELEASE_WAIT: begin
            if (is_none) begin
              if (cnt + 4'd1 == DB_TARGET) state <= IDLE;
              else                         cnt   <= cnt + 4'd1;
            end else if (is_cand) begin
              state <= HELD;
            end else begin
              cnt <= 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the PmodKYPD columns one at a time, synchronises
// the rows and reduces each full scan to one raw result for the debouncer.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] decode,
  output logic       key_valid
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [3:0]       row_s1, row_s2;
  logic [1:0]       hit_cnt;
  logic [3:0]       hit_key;
  logic [4:0]       raw_result;
  logic             scan_stb;

  logic [3:0] col_low;
  logic [2:0] col_pop;
  logic [3:0] col_key;
  logic [2:0] hit_sum;
  logic [1:0] acc_cnt;
  logic [3:0] acc_key;
  logic [4:0] raw_next;

  // fold the current column's rows into the running scan tally (0, 1, many)
  always_comb begin
    col_low = ~row_s2;
    col_pop = 3'(col_low[0]) + 3'(col_low[1]) + 3'(col_low[2]) + 3'(col_low[3]);
    col_key = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (col_low[r]) col_key = keymap(2'(r), col_idx);
    end
    hit_sum  = {1'b0, hit_cnt} + col_pop;
    acc_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    acc_key  = (hit_cnt == 2'd0) ? col_key : hit_key;
    case (acc_cnt)
      2'd0:    raw_next = RAW_NONE;
      2'd1:    raw_next = {1'b0, acc_key};
      default: raw_next = RAW_MULTI;
    endcase
  end

  // row synchroniser, column divider/rotation and end-of-scan result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1     <= 4'hF;
      row_s2     <= 4'hF;
      div_cnt    <= '0;
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      hit_cnt    <= 2'd0;
      hit_key    <= 4'h0;
      raw_result <= RAW_NONE;
      scan_stb   <= 1'b0;
    end else begin
      row_s1   <= row;
      row_s2   <= row_s1;
      scan_stb <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[2:0], col[3]};
        if (col_idx == 2'd3) begin
          raw_result <= raw_next;
          scan_stb   <= 1'b1;
          hit_cnt    <= 2'd0;
          hit_key    <= 4'h0;
        end else begin
          hit_cnt <= acc_cnt;
          hit_key <= acc_key;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .scan_stb (scan_stb),
    .raw      (raw_result),
    .decode   (decode),
    .key_valid(key_valid)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driven per scan, scan-level
// reference model of press/release acceptance, pulse monitor.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 3;
  localparam int RD       = 4;
  localparam int RP       = 2;
  localparam int SCAN_CLK = 4 * SCAN_DIV;
  localparam logic [3:0] LABEL [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                        4'h4, 4'h5, 4'h6, 4'hB,
                                        4'h7, 4'h8, 4'h9, 4'hC,
                                        4'h0, 4'hF, 4'hE, 4'hD};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] row, col, decode;
  logic key_valid;
  logic [15:0] pressed = 16'h0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .decode(decode), .key_valid(key_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ideal keypad: a row reads low when a pressed key sits on a driven column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // pulse monitor
  logic [3:0] got_q[$];
  int         got_cyc[$];
  int         consec = 0;
  logic       kv_prev = 1'b0;
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      got_q.push_back(decode);
      got_cyc.push_back(cyc);
      if (kv_prev === 1'b1) consec++;
    end
    kv_prev = key_valid;
  end

  // reference model: a press is accepted after DS consecutive scans of the
  // same lone key; it is released after DS consecutive key-free scans
  logic [3:0] exp_q[$];
  bit         m_locked;
  logic [3:0] m_key, m_last;
  int         m_run, m_rel, m_held;

  task automatic m_reset();
    m_locked = 0; m_key = 4'h0; m_last = 4'h0;
    m_run = 0; m_rel = 0; m_held = 0;
  endtask

  task automatic m_push(input logic [3:0] k);
    exp_q.push_back(k);
    m_last = k;
  endtask

  task automatic m_step(input logic [15:0] mask);
    int n;
    bit single;
    logic [3:0] k;
    n = $countones(mask);
    single = (n == 1);
    k = 4'h0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = LABEL[i];
    if (!m_locked) begin
      if (m_run > 0) begin
        if (single && k == m_key) m_run++;
        else m_run = 0;
      end else if (single) begin
        m_key = k; m_run = 1;
      end
      if (m_run >= DS) begin
        m_locked = 1; m_run = 0; m_rel = 0; m_held = 1;
        m_push(m_key);
      end
    end else begin
      if (m_rel == 0) begin
        if (n == 0) m_rel = 1;
        else if (single && k == m_key) begin
          m_held++;
`ifdef KEYPAD_REPEAT_EN
          if (m_held >= RD && ((m_held - RD) % RP) == 0) m_push(m_key);
`endif
        end
      end else begin
        if (n == 0) m_rel++;
        else if (single && k == m_key) m_rel = 0;
        else m_rel = 1;
      end
      if (m_rel >= DS) begin
        m_locked = 0; m_rel = 0;
      end
    end
  endtask

  // wait for the start of the next scan (col returns to 1110)
  task automatic next_scan();
    logic [3:0] p;
    bit found;
    found = 0;
    p = col;
    for (int i = 0; i < 3 * SCAN_CLK && !found; i++) begin
      @(posedge clk); #1;
      if (col == 4'b1110 && p != 4'b1110) found = 1;
      p = col;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL scan_align: col=%b never returned to 1110", col);
    end
  endtask

  task automatic do_scan(input logic [15:0] mask);
    pressed = mask;
    m_step(mask);
    next_scan();
  endtask

  task automatic clear_queues();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst = 1'b0;
    pressed = 16'h0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col); end
    checks++; if (decode !== 4'h0) begin errors++; $display("FAIL reset_decode: got %h expected 0", decode); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    @(negedge clk) rst = 1'b1;
    m_reset();
    clear_queues();
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      e = ~(4'b0001 << ((n / SCAN_DIV) % 4));
      checks++;
      if (col !== e) begin errors++; $display("FAIL col_seq[%0d]: got %b expected %b", n, col, e); end
    end
    m_step(pressed);
  endtask

  task automatic test_clean_press();
    int c0;
    clear_queues();
    c0 = cyc;
    repeat (6) do_scan(16'h0002);
    repeat (4) do_scan(16'h0000);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL clean_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (decode !== 4'h2) begin errors++; $display("FAIL clean_decode: got %h expected 2", decode); end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] - c0 > (DS + 1) * SCAN_CLK + 3) begin
      errors++;
      $display("FAIL clean_latency: got %0d expected <= %0d", (got_cyc.size() == 0) ? -1 : got_cyc[0] - c0, (DS + 1) * SCAN_CLK + 3);
    end
  endtask

  task automatic test_bounce();
    clear_queues();
    for (int i = 0; i < 8; i++) do_scan((i % 2 == 0) ? 16'h0008 : 16'h0000);
    repeat (4) do_scan(16'h0000);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bounce_count: got %0d expected 0", got_q.size()); end
    checks++; if (decode !== m_last) begin errors++; $display("FAIL bounce_decode: got %h expected %h", decode, m_last); end
  endtask

  task automatic test_multi();
    clear_queues();
    repeat (4) do_scan(16'h0021);
    do_scan(16'h0001);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_nopulse: got %0d expected %0d", got_q.size(), exp_q.size()); end
    repeat (3) do_scan(16'h0001);
    repeat (4) do_scan(16'h0000);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (decode !== 4'h1) begin errors++; $display("FAIL multi_decode: got %h expected 1", decode); end
  endtask

  task automatic test_back_to_back();
    int exp_n;
    bit all_d;
`ifdef KEYPAD_REPEAT_EN
    exp_n = 10;
`else
    exp_n = 2;
`endif
    clear_queues();
    consec = 0;
    repeat (20) do_scan(16'h8000);
    repeat (3)  do_scan(16'h0000);
    repeat (4)  do_scan(16'h8000);
    repeat (4)  do_scan(16'h0000);
    checks++; if (got_q.size() != exp_n) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_n); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_model_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    all_d = 1;
    foreach (got_q[i]) if (got_q[i] !== 4'hD) all_d = 0;
    checks++; if (!all_d) begin errors++; $display("FAIL b2b_codes: a pulse carried a code other than D"); end
    checks++; if (consec != 0) begin errors++; $display("FAIL b2b_consecutive: got %0d back-to-back pulses expected 0", consec); end
  endtask

  task automatic test_reset_mid();
    int rel;
    clear_queues();
    repeat (2) do_scan(16'h0100);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_nopulse: got %0d expected 0", got_q.size()); end
    checks++; if (decode !== 4'h0) begin errors++; $display("FAIL rstmid_decode: got %h expected 0", decode); end
    @(negedge clk) rst = 1'b1;
    rel = cyc;
    repeat (SCAN_CLK) @(posedge clk);
    #1;
    m_step(pressed);
    repeat (3) do_scan(16'h0100);
    repeat (4) do_scan(16'h0000);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (decode !== 4'h7) begin errors++; $display("FAIL rstmid_code: got %h expected 7", decode); end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] - rel != DS * SCAN_CLK + 1) begin
      errors++;
      $display("FAIL rstmid_latency: got %0d expected %0d", (got_cyc.size() == 0) ? -1 : got_cyc[0] - rel, DS * SCAN_CLK + 1);
    end
  endtask

  task automatic test_random();
    logic [15:0] m;
    int cur, kind, len, a, b, nmin;
    clear_queues();
    cur = $urandom_range(0, 15);
    for (int i = 0; i < 14; i++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      if (kind < 3) m = 16'h0;
      else if (kind < 7) m = 16'h1 << cur;
      else if (kind < 9) begin cur = $urandom_range(0, 15); m = 16'h1 << cur; end
      else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        m = (16'h1 << a) | (16'h1 << b);
      end
      for (int j = 0; j < len; j++) do_scan(m);
    end
    repeat (4) do_scan(16'h0000);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_code[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (decode !== m_last) begin errors++; $display("FAIL rand_decode: got %h expected %h", decode, m_last); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
